// File: rtl/rom_dl_if.sv
`default_nettype none
// ============================================================================
// rom_dl_if : hps_io ioctl download port plus the registered ROM write bus.
// Revision  : 1.0
// ============================================================================
interface rom_dl_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic [24:0] ADDR_DL;
    logic [7:0]  DATA_DL;
    logic        WR_MAIN;
    logic        WR_SND;
    logic        MAIN_LOADED;
    logic        SND_LOADED;
    logic        SIZE_ERR;
    logic        GAME_RESET;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  ADDR_DL, DATA_DL, WR_MAIN, WR_SND,
        input  MAIN_LOADED, SND_LOADED, SIZE_ERR, GAME_RESET
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output ADDR_DL, DATA_DL, WR_MAIN, WR_SND,
        output MAIN_LOADED, SND_LOADED, SIZE_ERR, GAME_RESET
    );
endinterface
`default_nettype wire

// File: rtl/rom_dl_ctrl.sv
`default_nettype none
// ============================================================================
// rom_dl_ctrl : routes ioctl bytes to main/sound ROMs, checks image sizes and
//               holds the game in reset until both images are loaded.
// Revision    : 1.0
// ============================================================================
module rom_dl_ctrl #(
    parameter logic [24:0] MAIN_SIZE = 25'hA000,
    parameter logic [24:0] SND_SIZE  = 25'h3000,
    parameter logic [7:0]  SND_INDEX = 8'd1,
    parameter int          HOLD_CYC  = 16
) (
    input  logic      CLK,
    input  logic      RESET_N,
    rom_dl_if.slave   bus
);
    localparam int              HW        = $clog2(HOLD_CYC + 1);
    localparam logic [HW-1:0]   HOLD_INIT = HW'(HOLD_CYC);
    localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    idx_q, idx_d;
    logic [24:0]   cnt_q, cnt_d;
    logic          over_q, over_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          dl_prev_q;
    logic [24:0]   addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          wr_main_q, wr_main_d;
    logic          wr_snd_q, wr_snd_d;
    logic          main_ld_q, main_ld_d;
    logic          snd_ld_q, snd_ld_d;
    logic          err_q, err_d;
    logic          gr_q, gr_d;

    logic        w_rise, w_fall, w_known_in, w_start, w_active;
    logic [7:0]  w_idx;
    logic        w_sel_main, w_sel_snd, w_wr;
    logic        w_wr_main, w_wr_snd, w_over;
    logic [24:0] w_exp_size;
    logic        w_img_ok, w_main_after, w_snd_after;

    assign w_rise     = bus.ioctl_download & ~dl_prev_q;
    assign w_fall     = ~bus.ioctl_download & dl_prev_q;
    assign w_known_in = (bus.ioctl_index == 8'd0) | (bus.ioctl_index == SND_INDEX);
    assign w_start    = w_rise & w_known_in & (state_q != LOAD);
    assign w_active   = (state_q == LOAD) | w_start;

    // The index is frozen at the download rise; later index changes are ignored.
    assign w_idx      = (state_q == LOAD) ? idx_q : bus.ioctl_index;
    assign w_sel_main = w_active & (w_idx == 8'd0);
    assign w_sel_snd  = w_active & (w_idx == SND_INDEX);
    assign w_wr       = bus.ioctl_wr & bus.ioctl_download;
    assign w_wr_main  = w_wr & w_sel_main & (bus.ioctl_addr < MAIN_SIZE);
    assign w_wr_snd   = w_wr & w_sel_snd  & (bus.ioctl_addr < SND_SIZE);
    assign w_over     = w_wr & ((w_sel_main & (bus.ioctl_addr >= MAIN_SIZE)) |
                                (w_sel_snd  & (bus.ioctl_addr >= SND_SIZE)));

    assign w_exp_size   = (idx_q == 8'd0) ? MAIN_SIZE : SND_SIZE;
    assign w_img_ok     = (cnt_q == w_exp_size) & ~over_q;
    assign w_main_after = (idx_q == 8'd0)    ? w_img_ok : main_ld_q;
    assign w_snd_after  = (idx_q == SND_INDEX) ? w_img_ok : snd_ld_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        over_d    = over_q;
        hold_d    = hold_q;
        main_ld_d = main_ld_q;
        snd_ld_d  = snd_ld_q;
        err_d     = err_q;
        gr_d      = gr_q;
        addr_d    = bus.ioctl_wr ? bus.ioctl_addr : addr_q;
        data_d    = bus.ioctl_wr ? bus.ioctl_dout : data_q;
        wr_main_d = w_wr_main;
        wr_snd_d  = w_wr_snd;

        case (state_q)
            LOAD: begin
                if (w_wr_main | w_wr_snd) begin
                    cnt_d = cnt_q + 25'd1;
                end
                if (w_over) begin
                    over_d = 1'b1;
                end
                if (w_fall) begin
                    if (w_img_ok) begin
                        if (idx_q == 8'd0) main_ld_d = 1'b1;
                        else               snd_ld_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (w_main_after & w_snd_after) begin
                        state_d = HOLD;
                        hold_d  = HOLD_INIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_d = RUN;
                    gr_d    = 1'b0;
                end else begin
                    hold_d = hold_q - HOLD_ONE;
                end
            end
            RUN:     gr_d = 1'b0;
            default: ;
        endcase

        // A new download wins over any other state, including an unfinished hold.
        if (w_start) begin
            state_d = LOAD;
            idx_d   = bus.ioctl_index;
            cnt_d   = (w_wr_main | w_wr_snd) ? 25'd1 : 25'd0;
            over_d  = w_over;
            gr_d    = 1'b1;
            if (bus.ioctl_index == 8'd0) main_ld_d = 1'b0;
            else                         snd_ld_d  = 1'b0;
        end
    end

    // dl_prev resets high so a download already running at reset release is not
    // mistaken for a fresh rise.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            idx_q     <= 8'd0;
            cnt_q     <= 25'd0;
            over_q    <= 1'b0;
            hold_q    <= '0;
            dl_prev_q <= 1'b1;
            addr_q    <= 25'd0;
            data_q    <= 8'd0;
            wr_main_q <= 1'b0;
            wr_snd_q  <= 1'b0;
            main_ld_q <= 1'b0;
            snd_ld_q  <= 1'b0;
            err_q     <= 1'b0;
            gr_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            over_q    <= over_d;
            hold_q    <= hold_d;
            dl_prev_q <= bus.ioctl_download;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wr_main_q <= wr_main_d;
            wr_snd_q  <= wr_snd_d;
            main_ld_q <= main_ld_d;
            snd_ld_q  <= snd_ld_d;
            err_q     <= err_d;
            gr_q      <= gr_d;
        end
    end

    assign bus.ADDR_DL     = addr_q;
    assign bus.DATA_DL     = data_q;
    assign bus.WR_MAIN     = wr_main_q;
    assign bus.WR_SND      = wr_snd_q;
    assign bus.MAIN_LOADED = main_ld_q;
    assign bus.SND_LOADED  = snd_ld_q;
    assign bus.SIZE_ERR    = err_q;
    assign bus.GAME_RESET  = gr_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_dl_ctrl.sv
`default_nettype none
// ============================================================================
// tb_rom_dl_ctrl : vector table, corner sequences and random downloads for
//                  rom_dl_ctrl, checked against a download-level model.
// Revision       : 1.0
// ============================================================================
module tb_rom_dl_ctrl;
    localparam logic [24:0] MAIN_SIZE = 25'h600;
    localparam logic [24:0] SND_SIZE  = 25'h180;
    localparam logic [7:0]  SND_INDEX = 8'd1;
    localparam int          HOLD_CYC  = 16;
    localparam int          M         = int'(MAIN_SIZE);
    localparam int          S         = int'(SND_SIZE);

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    rom_dl_if bus();

    rom_dl_ctrl #(
        .MAIN_SIZE (MAIN_SIZE),
        .SND_SIZE  (SND_SIZE),
        .SND_INDEX (SND_INDEX),
        .HOLD_CYC  (HOLD_CYC)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Download-level model: flags change only at download boundaries.
    bit         m_main, m_snd, m_err, m_gr, m_armed;
    logic [7:0] m_idx;

    // Expectation for the write launched in the previous cycle.
    bit          p_valid, p_main, p_snd;
    logic [24:0] p_addr;
    logic [7:0]  p_data;
    int          p_errs, p_got;

    typedef struct {
        bit         rst;
        logic [7:0] idx;
        int         nbytes;
        int         nover;
        bit         e_main;
        bit         e_snd;
        bit         e_err;
        bit         e_gr;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sample_path();
        if (bus.WR_MAIN !== p_main || bus.WR_SND !== p_snd) p_errs++;
        if (p_valid && (bus.ADDR_DL !== p_addr || bus.DATA_DL !== p_data)) p_errs++;
        if (bus.WR_MAIN === 1'b1 || bus.WR_SND === 1'b1) p_got++;
    endtask

    task automatic check_flags(input string tag);
        check({tag, ".main_loaded"}, bus.MAIN_LOADED, m_main);
        check({tag, ".snd_loaded"},  bus.SND_LOADED,  m_snd);
        check({tag, ".size_err"},    bus.SIZE_ERR,    m_err);
        check({tag, ".game_reset"},  bus.GAME_RESET,  m_gr);
    endtask

    task automatic do_reset();
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = 25'd0;
        bus.ioctl_dout     = 8'd0;
        RESET_N = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        m_main = 0; m_snd = 0; m_err = 0; m_gr = 1; m_armed = 0; m_idx = 8'd0;
        check("rst.wr_main", bus.WR_MAIN, 1'b0);
        check("rst.wr_snd",  bus.WR_SND,  1'b0);
        check("rst.addr",    bus.ADDR_DL, 25'd0);
        check_flags("rst");
    endtask

    task automatic download(input string tag, input logic [7:0] idx, input int nbytes,
                            input int nover, input bit rnd);
        int          lim;
        int          exp_acc;
        bit          over;
        bit          ok;
        bit          hold;
        logic [24:0] a;
        int          total;
        lim     = (idx == SND_INDEX) ? S : M;
        exp_acc = 0;
        over    = 0;
        hold    = 0;
        total   = nbytes + nover;
        p_valid = 0; p_main = 0; p_snd = 0; p_errs = 0; p_got = 0;

        @(negedge CLK);
        if (bus.ioctl_download !== 1'b1 && (idx == 8'd0 || idx == SND_INDEX)) begin
            m_armed = 1; m_idx = idx; m_gr = 1;
            if (idx == 8'd0) m_main = 0;
            else             m_snd  = 0;
        end
        bus.ioctl_download = 1'b1;
        bus.ioctl_index    = idx;

        for (int i = 0; i < total; i++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                @(negedge CLK);
                sample_path();
                bus.ioctl_wr = 1'b0;
                p_valid = 0; p_main = 0; p_snd = 0;
            end
            if (rnd && i == total / 2) bus.ioctl_index = 8'($urandom_range(0, 7));
            @(negedge CLK);
            sample_path();
            a = (i < nbytes) ? 25'(i) : 25'(lim + i - nbytes);
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = a;
            bus.ioctl_dout = rnd ? 8'($urandom) : a[7:0];
            p_valid = 1;
            p_addr  = a;
            p_data  = bus.ioctl_dout;
            p_main  = m_armed && m_idx == 8'd0      && a < MAIN_SIZE;
            p_snd   = m_armed && m_idx == SND_INDEX && a < SND_SIZE;
            if (p_main || p_snd) exp_acc++;
            else if (m_armed)    over = 1;
        end
        @(negedge CLK);
        sample_path();
        bus.ioctl_wr = 1'b0;
        bus.ioctl_download = 1'b0;
        p_valid = 0; p_main = 0; p_snd = 0;
        @(negedge CLK);
        sample_path();

        check({tag, ".wr_path_errs"}, p_errs, 0);
        check({tag, ".wr_count"}, p_got, exp_acc);

        if (m_armed) begin
            ok = (exp_acc == ((m_idx == 8'd0) ? M : S)) && !over;
            if (!ok)                 m_err  = 1;
            else if (m_idx == 8'd0)  m_main = 1;
            else                     m_snd  = 1;
            hold = m_main && m_snd;
            m_armed = 0;
        end
        check_flags(tag);

        // GAME_RESET must stay high HOLD_CYC more cycles, then drop.
        if (hold) begin
            repeat (HOLD_CYC) @(negedge CLK);
            check({tag, ".hold_high"}, bus.GAME_RESET, 1'b1);
            @(negedge CLK);
            check({tag, ".hold_low"}, bus.GAME_RESET, 1'b0);
            m_gr = 0;
        end
    endtask

    initial begin
        int post_wr;
        logic [7:0] ridx;
        int mode;
        int rlim;

        tbl[0]  = '{1, 8'd0,      M,     0, 1, 0, 0, 1};
        tbl[1]  = '{0, SND_INDEX, S,     0, 1, 1, 0, 0};
        tbl[2]  = '{1, 8'd0,      M - 1, 0, 0, 0, 1, 1};
        tbl[3]  = '{0, SND_INDEX, S,     0, 0, 1, 1, 1};
        tbl[4]  = '{1, 8'd0,      M,     2, 0, 0, 1, 1};
        tbl[5]  = '{0, 8'd5,      16,    0, 0, 0, 1, 1};
        tbl[6]  = '{0, 8'd0,      M,     0, 1, 0, 1, 1};
        tbl[7]  = '{0, SND_INDEX, S,     0, 1, 1, 1, 0};
        tbl[8]  = '{1, 8'd0,      M,     0, 1, 0, 0, 1};
        tbl[9]  = '{0, SND_INDEX, S,     0, 1, 1, 0, 0};
        tbl[10] = '{0, 8'd5,      16,    0, 1, 1, 0, 0};

        do_reset();

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rst) do_reset();
            download($sformatf("vec%0d", i), tbl[i].idx, tbl[i].nbytes, tbl[i].nover, 1'b0);
            check($sformatf("vec%0d.tbl_main", i), bus.MAIN_LOADED, tbl[i].e_main);
            check($sformatf("vec%0d.tbl_snd", i),  bus.SND_LOADED,  tbl[i].e_snd);
            check($sformatf("vec%0d.tbl_err", i),  bus.SIZE_ERR,    tbl[i].e_err);
            check($sformatf("vec%0d.tbl_gr", i),   bus.GAME_RESET,  tbl[i].e_gr);
        end

        // Reload of the sound image while running.
        @(negedge CLK);
        bus.ioctl_index = SND_INDEX;
        bus.ioctl_download = 1'b1;
        m_armed = 1; m_idx = SND_INDEX; m_snd = 0; m_gr = 1;
        @(negedge CLK);
        check("reload.game_reset", bus.GAME_RESET, 1'b1);
        check("reload.snd_loaded", bus.SND_LOADED, 1'b0);
        check("reload.main_loaded", bus.MAIN_LOADED, 1'b1);
        download("reload", SND_INDEX, S, 0, 1'b0);

        // Reset pulse in the middle of a main download.
        @(negedge CLK);
        bus.ioctl_index = 8'd0;
        bus.ioctl_download = 1'b1;
        for (int i = 0; i < 'h500; i++) begin
            @(negedge CLK);
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 25'(i);
            bus.ioctl_dout = 8'(i);
        end
        @(negedge CLK);
        RESET_N = 1'b0;
        bus.ioctl_addr = 25'h500;
        bus.ioctl_dout = 8'h00;
        #1;
        m_main = 0; m_snd = 0; m_err = 0; m_gr = 1; m_armed = 0;
        check("midrst.addr",    bus.ADDR_DL, 25'd0);
        check("midrst.data",    bus.DATA_DL, 8'd0);
        check("midrst.wr_main", bus.WR_MAIN, 1'b0);
        check("midrst.wr_snd",  bus.WR_SND,  1'b0);
        check_flags("midrst");
        @(negedge CLK);
        RESET_N = 1'b1;
        post_wr = 0;
        for (int i = 'h501; i < 'h540; i++) begin
            @(negedge CLK);
            if (bus.WR_MAIN === 1'b1 || bus.WR_SND === 1'b1) post_wr++;
            bus.ioctl_addr = 25'(i);
            bus.ioctl_dout = 8'(i);
        end
        @(negedge CLK);
        if (bus.WR_MAIN === 1'b1 || bus.WR_SND === 1'b1) post_wr++;
        bus.ioctl_wr = 1'b0;
        bus.ioctl_download = 1'b0;
        check("midrst.post_wr", post_wr, 0);
        @(negedge CLK);
        check_flags("midrst.after");
        download("after_rst", 8'd0, M, 0, 1'b0);

        // Random downloads against the model.
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
                0:       ridx = 8'd0;
                1:       ridx = SND_INDEX;
                2:       ridx = 8'd5;
                default: ridx = 8'd200;
            endcase
            mode = $urandom_range(0, 2);
            rlim = (ridx == SND_INDEX) ? S : M;
            download($sformatf("rnd%0d", k), ridx, (mode == 1) ? rlim - 1 : rlim,
                     (mode == 2) ? 1 : 0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
